// File: rtl/bf_pkg.sv
// Shared opcodes, error codes and controller state encoding for the Brainfuck execution core.
package bf_pkg;
    localparam logic [3:0] OP_LT   = 4'h0;
    localparam logic [3:0] OP_GT   = 4'h1;
    localparam logic [3:0] OP_INC  = 4'h2;
    localparam logic [3:0] OP_DEC  = 4'h3;
    localparam logic [3:0] OP_LOOP = 4'h4;
    localparam logic [3:0] OP_END  = 4'h5;
    localparam logic [3:0] OP_OUT  = 4'h6;
    localparam logic [3:0] OP_IN   = 4'h7;
    localparam logic [3:0] OP_STOP = 4'hF;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_UNF  = 2'd2;
    localparam logic [1:0] ERR_ILL  = 2'd3;

    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE   = 4'd0;
    localparam state_t ST_CLEAR  = 4'd1;
    localparam state_t ST_FETCH  = 4'd2;
    localparam state_t ST_DECODE = 4'd3;
    localparam state_t ST_SCAN_A = 4'd4;
    localparam state_t ST_SCAN_D = 4'd5;
    localparam state_t ST_OUT    = 4'd6;
    localparam state_t ST_IN     = 4'd7;
    localparam state_t ST_HALT   = 4'd8;
    localparam state_t ST_ERROR  = 4'd9;
endpackage

// File: rtl/bf_loop_stack.sv
// Loop-return stack: holds the pc of each open '[' so ']' can jump back without searching.
module bf_loop_stack
    import bf_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int SP_W = $clog2(DEPTH + 1);
    localparam int IX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]    mem [DEPTH];
    logic [SP_W-1:0] sp;

    assign full  = (sp == SP_W'(DEPTH));
    assign empty = (sp == '0);
    assign top   = mem[IX_W'(sp - 1'b1)];

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[IX_W'(sp)] <= push_data;
    end

    // Pushes when full and pops when empty are dropped so sp stays in 0..DEPTH.
    always_ff @(posedge clk) begin
        if (reset || clear)
            sp <= '0;
        else if (push && !full)
            sp <= sp + 1'b1;
        else if (pop && !empty)
            sp <= sp - 1'b1;
    end
endmodule

// File: rtl/bf_exec_ctrl.sv
// Brainfuck execution controller: FSM owning pc, dp, scan depth and RAM-clear counter,
// driving program ROM / data RAM and the input/output byte streams.
module bf_exec_ctrl
    import bf_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int DP_W        = 8,
    parameter int CELL_W      = 8,
    parameter int LOOP_DEPTH  = 16,
    parameter int CLEAR_ON_GO = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    output logic [PC_W-1:0]   prog_addr,
    input  logic [3:0]        prog_data,
    output logic [DP_W-1:0]   data_addr,
    input  logic [CELL_W-1:0] data_rdata,
    output logic [CELL_W-1:0] data_wdata,
    output logic              data_we,
    input  logic              in_valid,
    input  logic [CELL_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [CELL_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [1:0]        err_code
);
    state_t            state, state_n;
    logic [PC_W-1:0]   pc, pc_n, pc_inc, scan, scan_n;
    logic [DP_W-1:0]   dp, dp_n, clr, clr_n;
    logic [CELL_W-1:0] out_n;
    logic [1:0]        err_n;
    logic              push, pop, stk_clear, stk_full, stk_empty;
    logic [PC_W-1:0]   stk_top;

    bf_loop_stack #(.W(PC_W), .DEPTH(LOOP_DEPTH)) u_stack (
        .clk       (clk),
        .reset     (reset),
        .clear     (stk_clear),
        .push      (push),
        .pop       (pop),
        .push_data (pc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // pc is held across address and decode cycles, so the ROM sees it directly.
    assign pc_inc    = pc + 1'b1;
    assign prog_addr = pc;
    assign data_addr = (state == ST_CLEAR) ? clr : dp;
    assign out_valid = (state == ST_OUT);
    assign in_ready  = (state == ST_IN);
    assign halted    = (state == ST_HALT);
    assign err       = (state == ST_ERROR);
    assign busy      = !(state inside {ST_IDLE, ST_HALT, ST_ERROR});

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            pc       <= '0;
            dp       <= '0;
            scan     <= '0;
            clr      <= '0;
            out_data <= '0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            dp       <= dp_n;
            scan     <= scan_n;
            clr      <= clr_n;
            out_data <= out_n;
            err_code <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        dp_n       = dp;
        scan_n     = scan;
        clr_n      = clr;
        out_n      = out_data;
        err_n      = err_code;
        data_we    = 1'b0;
        data_wdata = '0;
        push       = 1'b0;
        pop        = 1'b0;
        stk_clear  = 1'b0;
        case (state)
            ST_IDLE: if (go) state_n = (CLEAR_ON_GO != 0) ? ST_CLEAR : ST_FETCH;
            ST_CLEAR: begin
                data_we = 1'b1;
                clr_n   = clr + 1'b1;
                if (clr == {DP_W{1'b1}}) state_n = ST_FETCH;
            end
            ST_FETCH: state_n = ST_DECODE;
            ST_DECODE: begin
                state_n = ST_FETCH;
                pc_n    = pc_inc;
                case (prog_data)
                    OP_LT: dp_n = dp - 1'b1;
                    OP_GT: dp_n = dp + 1'b1;
                    OP_INC: begin
                        data_we    = 1'b1;
                        data_wdata = data_rdata + 1'b1;
                    end
                    OP_DEC: begin
                        data_we    = 1'b1;
                        data_wdata = data_rdata - 1'b1;
                    end
                    OP_LOOP: begin
                        if (data_rdata == '0) begin
                            scan_n  = PC_W'(1);
                            state_n = ST_SCAN_A;
                        end else if (stk_full) begin
                            pc_n    = pc;
                            err_n   = ERR_OVF;
                            state_n = ST_ERROR;
                        end else begin
                            push = 1'b1;
                        end
                    end
                    // Empty-stack check wins over the cell value.
                    OP_END: begin
                        if (stk_empty) begin
                            pc_n    = pc;
                            err_n   = ERR_UNF;
                            state_n = ST_ERROR;
                        end else if (data_rdata != '0) begin
                            pc_n = stk_top + 1'b1;
                        end else begin
                            pop = 1'b1;
                        end
                    end
                    OP_OUT: begin
                        pc_n    = pc;
                        out_n   = data_rdata;
                        state_n = ST_OUT;
                    end
                    OP_IN: begin
                        pc_n    = pc;
                        state_n = ST_IN;
                    end
                    OP_STOP: begin
                        pc_n    = pc;
                        state_n = ST_HALT;
                    end
                    default: begin
                        pc_n    = pc;
                        err_n   = ERR_ILL;
                        state_n = ST_ERROR;
                    end
                endcase
            end
            ST_SCAN_A: state_n = ST_SCAN_D;
            ST_SCAN_D: begin
                pc_n    = pc_inc;
                state_n = ST_SCAN_A;
                if (prog_data == OP_LOOP) begin
                    scan_n = scan + 1'b1;
                end else if (prog_data == OP_END) begin
                    scan_n = scan - 1'b1;
                    if (scan == PC_W'(1)) state_n = ST_FETCH;
                end
            end
            ST_OUT: if (out_ready) begin
                pc_n    = pc_inc;
                state_n = ST_FETCH;
            end
            ST_IN: if (in_valid) begin
                data_we    = 1'b1;
                data_wdata = in_data;
                pc_n       = pc_inc;
                state_n    = ST_FETCH;
            end
            // Leaving ERROR rewinds the machine so the next go restarts the program.
            ST_ERROR: if (go) begin
                err_n     = ERR_NONE;
                pc_n      = '0;
                dp_n      = '0;
                scan_n    = '0;
                stk_clear = 1'b1;
                state_n   = ST_IDLE;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_bf_exec_ctrl.sv
// Bench for bf_exec_ctrl: ROM/RAM models, output scoreboard, and one task per scenario.
module tb_bf_exec_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic [7:0] prog_addr;
    logic [3:0] prog_data;
    logic [7:0] data_addr, data_rdata, data_wdata;
    logic       data_we;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;
    logic       busy, halted, err;
    logic [1:0] err_code;

    logic [3:0] rom [256];
    logic [7:0] ram [256];
    logic       ram_fill = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         n_cmp = 0, n_bad = 0, n_in = 0;

    always #5 clk = ~clk;

    bf_exec_ctrl dut (
        .clk(clk), .reset(reset), .go(go),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .data_addr(data_addr), .data_rdata(data_rdata), .data_wdata(data_wdata), .data_we(data_we),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .halted(halted), .err(err), .err_code(err_code)
    );

    always @(posedge clk) begin
        prog_data  <= rom[prog_addr];
        data_rdata <= ram[data_addr];
        if (ram_fill) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'hA5;
        end else if (data_we) begin
            ram[data_addr] <= data_wdata;
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) got_q.push_back(out_data);
        if (!reset && in_valid && in_ready) n_in++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; go = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        got_q.delete(); exp_q.delete(); n_in = 0;
    endtask

    task automatic load(input string s);
        for (int i = 0; i < 256; i++) rom[i] = 4'hF;
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "<": rom[i] = 4'h0;  ">": rom[i] = 4'h1;
                "+": rom[i] = 4'h2;  "-": rom[i] = 4'h3;
                "[": rom[i] = 4'h4;  "]": rom[i] = 4'h5;
                ".": rom[i] = 4'h6;  ",": rom[i] = 4'h7;
                "9": rom[i] = 4'h9;
                default: rom[i] = 4'hF;
            endcase
        end
    endtask

    task automatic start();
        go = 1'b1; tick(); go = 1'b0;
    endtask

    task automatic run(input int budget, output bit timed_out);
        int k;
        k = 0;
        while (!halted && !err && k < budget) begin tick(); k++; end
        timed_out = !(halted || err);
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick();
        n_cmp++;
        if ({busy, halted, err, err_code, out_valid, in_ready, data_we} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 00000000", {busy, halted, err, err_code, out_valid, in_ready, data_we});
        end
        n_cmp++;
        if (prog_addr !== 8'd0 || data_addr !== 8'd0) begin
            n_bad++; $display("FAIL reset_addr got pc=%0d dp=%0d want 0/0", prog_addr, data_addr);
        end
        reset = 1'b0; tick(); tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_go got busy=%b want 0", busy); end
    endtask

    task automatic test_out_stall();
        bit to; int k, bad; logic [7:0] e, g;
        do_reset(); load("+++.F"); exp_q.push_back(8'd3);
        out_ready = 1'b0; start();
        k = 0;
        while (!out_valid && k < 1000) begin tick(); k++; end
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_wait got out_valid=%b want 1", out_valid); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_data !== 8'd3) bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
        out_ready = 1'b1; run(100, to);
        n_cmp++;
        if (to || halted !== 1'b1) begin n_bad++; $display("FAIL stall_halt got halted=%b want 1", halted); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (got_q.size() == 0) begin n_bad++; $display("FAIL stall_out got none want %0d", e); end
            else begin g = got_q.pop_front(); if (g !== e) begin n_bad++; $display("FAIL stall_out got %0d want %0d", g, e); end end
        end
        n_cmp++;
        if (got_q.size() != 0) begin n_bad++; $display("FAIL stall_extra got %0d extra want 0", got_q.size()); end
    endtask

    task automatic test_nested();
        bit to; logic [7:0] e, g;
        do_reset(); load("++[>++[>+<-]<-]>>.F"); exp_q.push_back(8'd4);
        start(); run(3000, to);
        n_cmp++;
        if (to || halted !== 1'b1) begin n_bad++; $display("FAIL nested_halt got halted=%b want 1", halted); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (got_q.size() == 0) begin n_bad++; $display("FAIL nested_out got none want %0d", e); end
            else begin g = got_q.pop_front(); if (g !== e) begin n_bad++; $display("FAIL nested_out got %0d want %0d", g, e); end end
        end
        n_cmp++;
        if (got_q.size() != 0) begin n_bad++; $display("FAIL nested_extra got %0d extra want 0", got_q.size()); end
        n_cmp++;
        if (dut.u_stack.sp !== '0) begin n_bad++; $display("FAIL nested_sp got %0d want 0", dut.u_stack.sp); end
    endtask

    task automatic test_skip();
        bit to; logic [7:0] e, g;
        do_reset(); load("[+[+]+]+.F"); exp_q.push_back(8'd1);
        start(); run(1000, to);
        n_cmp++;
        if (to || halted !== 1'b1) begin n_bad++; $display("FAIL skip_halt got halted=%b want 1", halted); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (got_q.size() == 0) begin n_bad++; $display("FAIL skip_out got none want %0d", e); end
            else begin g = got_q.pop_front(); if (g !== e) begin n_bad++; $display("FAIL skip_out got %0d want %0d", g, e); end end
        end
        n_cmp++;
        if (got_q.size() != 0) begin n_bad++; $display("FAIL skip_extra got %0d extra want 0", got_q.size()); end
    endtask

    task automatic test_input();
        bit to; int k; logic [7:0] e, g;
        do_reset(); load(",.F"); exp_q.push_back(8'h5A);
        start();
        k = 0;
        while (!in_ready && k < 1000) begin tick(); k++; end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL in_wait got in_ready=%b want 1", in_ready); end
        for (int i = 0; i < 5; i++) tick();
        in_data = 8'h5A; in_valid = 1'b1;
        run(200, to);
        n_cmp++;
        if (to || halted !== 1'b1) begin n_bad++; $display("FAIL in_halt got halted=%b want 1", halted); end
        n_cmp++;
        if (n_in != 1) begin n_bad++; $display("FAIL in_handshakes got %0d want 1", n_in); end
        in_valid = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (got_q.size() == 0) begin n_bad++; $display("FAIL in_out got none want %0d", e); end
            else begin g = got_q.pop_front(); if (g !== e) begin n_bad++; $display("FAIL in_out got %0h want %0h", g, e); end end
        end
    endtask

    task automatic test_wrap();
        bit to; logic [7:0] e, g;
        do_reset(); load("<.F"); exp_q.push_back(8'd0);
        start(); run(1000, to);
        n_cmp++;
        if (to || data_addr !== 8'hFF) begin n_bad++; $display("FAIL wrap_dp got %0d want 255", data_addr); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (got_q.size() == 0) begin n_bad++; $display("FAIL wrap_out got none want %0d", e); end
            else begin g = got_q.pop_front(); if (g !== e) begin n_bad++; $display("FAIL wrap_out got %0d want %0d", g, e); end end
        end
    endtask

    task automatic test_errors();
        bit to; string s;
        do_reset(); load("]F"); start(); run(1000, to);
        n_cmp++;
        if (to || err !== 1'b1 || err_code !== 2'd2 || prog_addr !== 8'd0) begin
            n_bad++; $display("FAIL err_unf got err=%b code=%0d pc=%0d want 1/2/0", err, err_code, prog_addr);
        end
        s = "+";
        for (int i = 0; i < 17; i++) s = {s, "["};
        do_reset(); load(s); start(); run(1000, to);
        n_cmp++;
        if (to || err !== 1'b1 || err_code !== 2'd1 || prog_addr !== 8'd17) begin
            n_bad++; $display("FAIL err_ovf got err=%b code=%0d pc=%0d want 1/1/17", err, err_code, prog_addr);
        end
        tick(); tick();
        n_cmp++;
        if (err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL err_sticky got err=%b code=%0d busy=%b want 1/1/0", err, err_code, busy);
        end
        start();
        n_cmp++;
        if (err !== 1'b0 || err_code !== 2'd0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL err_go_clear got err=%b code=%0d busy=%b want 0/0/0", err, err_code, busy);
        end
        do_reset(); load("9"); start(); run(1000, to);
        n_cmp++;
        if (to || err !== 1'b1 || err_code !== 2'd3) begin
            n_bad++; $display("FAIL err_ill got err=%b code=%0d want 1/3", err, err_code);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        do_reset(); load("+++.F"); out_ready = 1'b0; start();
        k = 0;
        while (!out_valid && k < 1000) begin tick(); k++; end
        reset = 1'b1; tick();
        n_cmp++;
        if ({out_valid, data_we, busy} !== 3'b000) begin
            n_bad++; $display("FAIL rst_out got valid/we/busy=%b want 000", {out_valid, data_we, busy});
        end
        reset = 1'b0; out_ready = 1'b1;
        ram_fill = 1'b1; tick(); ram_fill = 1'b0;
        load("+.F"); start();
        k = 0;
        while (!(data_we && data_addr == 8'd37) && k < 100) begin tick(); k++; end
        n_cmp++;
        if (data_addr !== 8'd37) begin n_bad++; $display("FAIL rst_clr_wait got addr=%0d want 37", data_addr); end
        reset = 1'b1; tick();
        n_cmp++;
        if ({out_valid, data_we, busy} !== 3'b000) begin
            n_bad++; $display("FAIL rst_clr got valid/we/busy=%b want 000", {out_valid, data_we, busy});
        end
        tick();
        n_cmp++;
        if (ram[37] !== 8'h00 || ram[38] !== 8'hA5) begin
            n_bad++; $display("FAIL rst_clr_ram got c37=%0h c38=%0h want 0/a5", ram[37], ram[38]);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_out_stall();
        test_nested();
        test_skip();
        test_input();
        test_wrap();
        test_errors();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
